// File: rtl/tipi_rpi_shift_master.sv
// tipi_rpi_shift_master: initiator side of the TIPI serial register link.
// Ports: clk/reset_n (async active-low); req_valid/req_ready/req_write/req_dc/req_data byte request;
// rsp_valid/rsp_data completion; r_clk/r_dc/r_rt/r_le/r_dout/r_din serial link to the CPLD;
// r_reset async TI reset input, ti_reset synchronised copy, ti_reset_rise rising-edge pulse.
module tipi_rpi_shift_master #(
  parameter int HALF_PER = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_dc,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       r_clk,
  output logic       r_dc,
  output logic       r_rt,
  output logic       r_le,
  output logic       r_dout,
  input  logic       r_din,
  input  logic       r_reset,
  output logic       ti_reset,
  output logic       ti_reset_rise
);
  localparam int CW = HALF_PER > 1 ? $clog2(HALF_PER) : 1;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_HI    = 3'd4;
  localparam logic [2:0] S_LATCH = 3'd5;
  localparam logic [2:0] S_TAIL  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;
  logic [2:0] state, nxt, bit_idx;
  logic [CW-1:0] cnt;
  logic [7:0] data, shreg;
  logic wr, last, accept, sync1;
  assign last = cnt == CW'(HALF_PER - 1);
  assign req_ready = state == S_IDLE;
  assign accept = req_valid & req_ready;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = req_valid ? S_SETUP : S_IDLE;
      S_SETUP: nxt = last ? (wr ? S_LO : S_LOAD) : state;
      S_LOAD:  nxt = last ? S_LO : state;
      S_LO:    nxt = last ? S_HI : state;
      S_HI:    nxt = last ? (bit_idx != 3'd7 ? S_LO : wr ? S_LATCH : S_TAIL) : state;
      S_LATCH: nxt = last ? S_TAIL : state;
      S_TAIL:  nxt = last ? S_DONE : state;
      default: nxt = S_IDLE;
    endcase
  end
  // Link outputs are registered from the next state so they change cleanly on clk edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      wr        <= 1'b0;
      data      <= '0;
      shreg     <= '0;
      r_clk     <= 1'b0;
      r_le      <= 1'b0;
      r_dout    <= 1'b0;
      r_rt      <= 1'b1;
      r_dc      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= nxt;
      cnt       <= nxt != state ? '0 : cnt + 1'b1;
      r_clk     <= nxt == S_HI;
      r_le      <= nxt == S_LOAD || nxt == S_LATCH;
      rsp_valid <= nxt == S_DONE;
      if (accept) begin
        wr      <= req_write;
        data    <= req_data;
        r_rt    <= ~req_write;
        r_dc    <= req_dc;
        r_dout  <= req_write & req_data[7];
        bit_idx <= '0;
      end
      // Read bit is taken on the last LO cycle, just before r_clk rises and the CPLD shifts.
      if (state == S_LO && last && !wr) shreg <= {shreg[6:0], r_din};
      // End of HI is the r_clk falling edge: present the next write bit for the coming rise.
      if (state == S_HI && last) begin
        bit_idx <= bit_idx + 1'b1;
        if (wr && bit_idx != 3'd7) r_dout <= data[3'd6 - bit_idx];
      end
      if (nxt == S_TAIL) r_dout <= 1'b0;
      if (nxt == S_DONE) rsp_data <= wr ? data : shreg;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1         <= 1'b0;
      ti_reset      <= 1'b0;
      ti_reset_rise <= 1'b0;
    end else begin
      sync1         <= r_reset;
      ti_reset      <= sync1;
      ti_reset_rise <= sync1 & ~ti_reset;
    end
  end
endmodule

// File: tb/tb_tipi_rpi_shift_master.sv
// tb_tipi_rpi_shift_master: two DUTs (HALF_PER 2 and 1) driven against a CPLD shift-register model.
module tb_tipi_rpi_shift_master;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic r_reset = 1'b0;
  logic [1:0] req_valid = '0, req_write = '0, req_dc = '0;
  logic [1:0] req_ready, rsp_valid, r_clk, r_dc, r_rt, r_le, r_dout, r_din, ti_reset, ti_reset_rise;
  logic [7:0] req_data [2] = '{default: 8'h00};
  logic [7:0] rsp_data [2];
  logic [7:0] load [2] = '{default: 8'h00};
  logic [7:0] cpld_sr [2] = '{default: 8'h00};
  logic [7:0] wsr [2] = '{default: 8'h00};
  logic [7:0] latched [2] = '{default: 8'h00};
  logic [1:0] pclk = '0, ple = '0;
  int rises [2] = '{default: 0};
  int les [2] = '{default: 0};
  int lecyc [2] = '{default: 0};
  int le_at [2] = '{default: 0};
  int ov [2] = '{default: 0};
  int rcnt [2] = '{default: 0};
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    tipi_rpi_shift_master #(.HALF_PER(g == 0 ? 2 : 1)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
      .req_dc(req_dc[g]), .req_data(req_data[g]),
      .rsp_valid(rsp_valid[g]), .rsp_data(rsp_data[g]),
      .r_clk(r_clk[g]), .r_dc(r_dc[g]), .r_rt(r_rt[g]), .r_le(r_le[g]),
      .r_dout(r_dout[g]), .r_din(r_din[g]),
      .r_reset(r_reset), .ti_reset(ti_reset[g]), .ti_reset_rise(ti_reset_rise[g])
    );
    assign r_din[g] = cpld_sr[g][7];
  end
  // CPLD model: r_le loads TD/TC (read) or latches RD/RC (write); each r_clk rise shifts one bit.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pclk[i] <= r_clk[i];
      ple[i]  <= r_le[i];
      if (r_clk[i] && !pclk[i]) begin
        rises[i]   <= rises[i] + 1;
        wsr[i]     <= {wsr[i][6:0], r_dout[i]};
        cpld_sr[i] <= cpld_sr[i] << 1;
      end
      if (r_le[i] && !ple[i]) begin
        les[i]   <= les[i] + 1;
        le_at[i] <= rises[i];
        if (r_rt[i]) cpld_sr[i] <= load[i];
        else latched[i] <= wsr[i];
      end
      if (r_le[i]) lecyc[i] <= lecyc[i] + 1;
      if (r_le[i] && r_clk[i]) ov[i] <= ov[i] + 1;
      if (ti_reset_rise[i]) rcnt[i] <= rcnt[i] + 1;
    end
  end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
  endtask
  // One full transaction; expectations come from the link rules: 19*H phase cycles, 8 rises,
  // one r_le pulse of H cycles placed before the rises (read) or after them (write).
  task automatic txn(input int i, input bit wr, input bit dc, input logic [7:0] d,
                     input logic [7:0] ld, input logic [7:0] ex, input string nm);
    int h, lat, r0, l0, c0;
    h = (i == 0) ? 2 : 1;
    load[i] = ld;
    req_write[i] = wr;
    req_dc[i] = dc;
    req_data[i] = d;
    req_valid[i] = 1'b1;
    r0 = rises[i];
    l0 = les[i];
    c0 = lecyc[i];
    check({nm, "_ready_idle"}, int'(req_ready[i]), 1);
    tick;
    req_valid[i] = 1'b0;
    lat = 1;
    while (!rsp_valid[i] && lat < 200) begin
      tick;
      lat++;
    end
    check({nm, "_latency"}, lat, 19 * h + 1);
    check({nm, "_rsp_data"}, int'(rsp_data[i]), int'(ex));
    check({nm, "_rises"}, rises[i] - r0, 8);
    check({nm, "_le_pulses"}, les[i] - l0, 1);
    check({nm, "_le_cycles"}, lecyc[i] - c0, h);
    check({nm, "_le_order"}, le_at[i] - r0, wr ? 8 : 0);
    check({nm, "_r_rt"}, int'(r_rt[i]), int'(!wr));
    check({nm, "_r_dc"}, int'(r_dc[i]), int'(dc));
    check({nm, "_dout_tail"}, int'(r_dout[i]), 0);
    if (wr) check({nm, "_latched"}, int'(latched[i]), int'(d));
    tick;
    check({nm, "_ready_after"}, int'(req_ready[i]), 1);
  endtask
  typedef struct {
    int inst;
    bit wr;
    bit dc;
    logic [7:0] d;
    logic [7:0] ld;
    logic [7:0] ex;
  } vec_t;
  vec_t tv [6];
  int n, rc0, rc1, first, second, rdy_bad, vsum;
  logic [7:0] d1, d2;
  initial begin
    tv = '{'{0, 1'b1, 1'b1, 8'hA5, 8'h00, 8'hA5},
           '{0, 1'b0, 1'b0, 8'h00, 8'h3C, 8'h3C},
           '{1, 1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF},
           '{1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00},
           '{1, 1'b1, 1'b0, 8'h81, 8'h00, 8'h81},
           '{0, 1'b1, 1'b0, 8'h7E, 8'hFF, 8'h7E}};
    repeat (3) tick;
    check("rst_r_clk", int'(r_clk[0]), 0);
    check("rst_r_le", int'(r_le[0]), 0);
    check("rst_r_dout", int'(r_dout[0]), 0);
    check("rst_r_rt", int'(r_rt[0]), 1);
    check("rst_r_dc", int'(r_dc[0]), 0);
    check("rst_rsp_valid", int'(rsp_valid[0]), 0);
    check("rst_rsp_data", int'(rsp_data[0]), 0);
    check("rst_ti_reset", int'(ti_reset[0]), 0);
    check("rst_req_ready", int'(req_ready[0]), 1);
    reset_n = 1'b1;
    tick;
    for (int k = 0; k < 6; k++)
      txn(tv[k].inst, tv[k].wr, tv[k].dc, tv[k].d, tv[k].ld, tv[k].ex, $sformatf("vec%0d", k));
    // Back-to-back: req_valid held high across two requests.
    load[0] = 8'hC3;
    req_write[0] = 1'b1;
    req_dc[0] = 1'b1;
    req_data[0] = 8'h01;
    req_valid[0] = 1'b1;
    first = -1;
    second = -1;
    rdy_bad = 0;
    d1 = 8'h00;
    d2 = 8'h00;
    for (int c = 0; c < 90; c++) begin
      if (c >= 1 && c <= 39 && req_ready[0]) rdy_bad++;
      if (c == 1) begin
        req_write[0] = 1'b0;
        req_data[0] = 8'h00;
      end
      if (c == 40) check("b2b_ready_c40", int'(req_ready[0]), 1);
      if (c == 41) req_valid[0] = 1'b0;
      if (rsp_valid[0]) begin
        if (first < 0) begin
          first = c;
          d1 = rsp_data[0];
        end else begin
          second = c;
          d2 = rsp_data[0];
        end
      end
      tick;
    end
    check("b2b_ready_low", rdy_bad, 0);
    check("b2b_first_cyc", first, 39);
    check("b2b_second_cyc", second, 79);
    check("b2b_first_data", int'(d1), 8'h01);
    check("b2b_second_data", int'(d2), 8'hC3);
    // Reset after the 3rd rise of a write aborts it at once.
    req_write[0] = 1'b1;
    req_dc[0] = 1'b0;
    req_data[0] = 8'hF0;
    req_valid[0] = 1'b1;
    rc0 = rises[0];
    tick;
    req_valid[0] = 1'b0;
    n = 0;
    while (rises[0] - rc0 < 3 && n < 100) begin
      tick;
      n++;
    end
    check("abort_reach_rise3", rises[0] - rc0, 3);
    reset_n = 1'b0;
    #1;
    check("abort_r_clk", int'(r_clk[0]), 0);
    check("abort_r_le", int'(r_le[0]), 0);
    check("abort_r_rt", int'(r_rt[0]), 1);
    check("abort_ready", int'(req_ready[0]), 1);
    vsum = 0;
    repeat (4) begin
      tick;
      vsum += int'(rsp_valid[0]);
    end
    reset_n = 1'b1;
    repeat (60) begin
      tick;
      vsum += int'(rsp_valid[0]);
    end
    check("abort_no_rsp", vsum, 0);
    txn(0, 1'b1, 1'b0, 8'h5A, 8'h00, 8'h5A, "wr_after_abort");
    // r_reset rising during a read: synchronised, one pulse, read unaffected.
    fork
      txn(0, 1'b0, 1'b1, 8'h00, 8'h96, 8'h96, "rd_rreset");
      begin
        repeat (6) tick;
        rc0 = rcnt[0];
        rc1 = rcnt[1];
        r_reset = 1'b1;
        n = 0;
        while (!ti_reset[0] && n < 10) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("ti_reset_sync_lat", int'(n >= 2 && n <= 3), 1);
        repeat (20) tick;
        check("ti_reset_held", int'(ti_reset[0]), 1);
        check("ti_rise_once_0", rcnt[0] - rc0, 1);
        check("ti_rise_once_1", rcnt[1] - rc1, 1);
      end
    join
    r_reset = 1'b0;
    repeat (5) tick;
    check("ti_reset_fall", int'(ti_reset[0]), 0);
    check("ti_rise_none_on_fall", rcnt[0] - rc0, 1);
    for (int k = 0; k < 24; k++) begin
      int i;
      bit wr, dc;
      logic [7:0] d, ld;
      i = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      dc = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      ld = 8'($urandom);
      txn(i, wr, dc, d, ld, wr ? d : ld, $sformatf("rnd%0d", k));
    end
    check("le_clk_overlap_0", ov[0], 0);
    check("le_clk_overlap_1", ov[1], 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
